// File: rtl/if_pc_fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
package if_pc_fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [XLEN-1:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] PC_INC          = 32'd4;

    // Instruction word together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_inst_t;

    function automatic logic [XLEN-1:0] inst_align(input logic [XLEN-1:0] addr);
        return addr & INST_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_pc_fetch.sv
// PC register and single-outstanding instruction fetch with redirect support.
// A redirect while a request is in flight marks the response for discard.
module if_pc_fetch
    import if_pc_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] jmp_to,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_err
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] req_addr, req_addr_next;
    logic            drop, drop_next;
    fetch_inst_t     held, held_next;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic            misalign_next;

    assign redirect      = jmp_en && (state != S_IDLE);
    assign target        = inst_align(jmp_to);
    assign misalign_next = redirect && (jmp_to[1:0] != 2'b00);

    // Next-PC selection: redirect beats sequential advance, otherwise hold.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = target;
        end else if (state == S_HOLD && inst_ready) begin
            pc_next = pc + PC_INC;
        end
    end

    // Next-state and fetch bookkeeping.
    always_comb begin
        state_next    = state;
        req_addr_next = req_addr;
        drop_next     = drop;
        held_next     = held;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    drop_next = 1'b1;
                end
                if (imem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    drop_next = 1'b1;
                end
                if (imem_rsp_valid) begin
                    if (drop || redirect) begin
                        drop_next     = 1'b0;
                        req_addr_next = pc_next;
                        state_next    = S_REQ;
                    end else begin
                        held_next  = '{pc: req_addr, word: imem_rsp_data};
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect || inst_ready) begin
                    req_addr_next = pc_next;
                    state_next    = S_REQ;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; valids are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            req_addr       <= RESET_PC;
            drop           <= 1'b0;
            held           <= '{pc: RESET_PC, word: '0};
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            misalign_err   <= 1'b0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            req_addr       <= req_addr_next;
            drop           <= drop_next;
            held           <= held_next;
            imem_req_valid <= (state_next == S_REQ);
            inst_valid     <= (state_next == S_HOLD);
            misalign_err   <= misalign_next;
        end
    end

    assign imem_req_addr = req_addr;
    assign inst          = held.word;
    assign inst_pc       = held.pc;

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed and randomized bench for if_pc_fetch: a transaction-level fetch-stream
// model plus a bench-owned instruction memory with configurable response latency.
module tb_if_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        jmp_en;
    logic [31:0] jmp_to;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign_err;

    always #5 clk = ~clk;

    if_pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .jmp_en         (jmp_en),
        .jmp_to         (jmp_to),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misalign_err   (misalign_err)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Memory model: one pending request, response presented after mem_lat extra cycles.
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    bit          rand_lat = 1'b0;
    logic [31:0] mem_addr = '0;
    bit          last_acc = 1'b0;
    logic [31:0] last_acc_addr = '0;

    // Reference fetch stream: address the next consumed instruction must have.
    logic [31:0] exp_pc = 32'h0;
    int          n_hs   = 0;
    logic [31:0] hs_pc[$];
    int          hs_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_A5A5) + {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_valid"},  32'(imem_req_valid), 32'd0);
        check({tag, "_req_addr"},   imem_req_addr,       32'h0);
        check({tag, "_inst_valid"}, 32'(inst_valid),     32'd0);
        check({tag, "_inst"},       inst,                32'h0);
        check({tag, "_inst_pc"},    inst_pc,             32'h0);
        check({tag, "_misalign"},   32'(misalign_err),   32'd0);
    endtask

    // One clock: observe what happened at the edge, update models, drive memory side.
    task automatic step();
        logic        p_req_valid, p_inst_valid, acc, hs;
        logic [31:0] p_req_addr, p_inst, p_inst_pc;
        p_req_valid  = imem_req_valid;
        p_req_addr   = imem_req_addr;
        p_inst_valid = inst_valid;
        p_inst       = inst;
        p_inst_pc    = inst_pc;
        @(posedge clk);
        #1;
        cyc++;
        acc      = !rst && p_req_valid && imem_req_ready;
        hs       = !rst && p_inst_valid && inst_ready;
        last_acc = acc;
        check("misalign_err", 32'(misalign_err),
              32'(!rst && jmp_en && (jmp_to[1:0] != 2'b00)));
        if (!rst && p_req_valid && !imem_req_ready) begin
            check("req_held_valid", 32'(imem_req_valid), 32'd1);
            check("req_held_addr", imem_req_addr, p_req_addr);
        end
        if (imem_req_valid) check("req_addr_align", 32'(imem_req_addr[1:0]), 32'd0);
        if (hs) begin
            check("inst_pc", p_inst_pc, exp_pc);
            check("inst", p_inst, mem_word(p_inst_pc));
            exp_pc = exp_pc + 32'd4;
            n_hs++;
            hs_pc.push_back(p_inst_pc);
            hs_cyc.push_back(cyc);
        end
        if (!rst && jmp_en) exp_pc = jmp_to & 32'hFFFF_FFFC;
        if (rst) begin
            exp_pc         = 32'h0;
            mem_pend       = 1'b0;
            imem_rsp_valid = 1'b0;
        end else begin
            if (imem_rsp_valid) begin
                mem_pend       = 1'b0;
                imem_rsp_valid = 1'b0;
            end else if (mem_pend) begin
                mem_cnt--;
            end
            if (acc) begin
                check("one_outstanding", 32'(mem_pend), 32'd0);
                if (rand_lat) mem_lat = $urandom_range(1, 4);
                mem_pend      = 1'b1;
                mem_cnt       = mem_lat;
                mem_addr      = p_req_addr;
                last_acc_addr = p_req_addr;
            end
            if (mem_pend && mem_cnt <= 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
            end
        end
        jmp_en = 1'b0;
    endtask

    task automatic run_until_hs(input string tag, input int target_n, input int budget);
        int k = 0;
        while (n_hs < target_n && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(n_hs >= target_n), 32'd1);
    endtask

    task automatic wait_inst(input string tag, input int budget);
        int k = 0;
        while (!inst_valid && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(inst_valid), 32'd1);
    endtask

    task automatic wait_acc(input string tag, input int budget);
        int k = 0;
        step();
        while (!last_acc && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(last_acc), 32'd1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr, input int budget);
        int k = 0;
        while (!imem_req_valid && k < budget) begin
            step();
            k++;
        end
        check({tag, "_valid"}, 32'(imem_req_valid), 32'd1);
        check({tag, "_addr"}, imem_req_addr, addr);
    endtask

    initial begin
        int base;
        rst            = 1'b1;
        jmp_en         = 1'b0;
        jmp_to         = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;

        // Reset held for three cycles; request appears in the second cycle after release.
        repeat (3) step();
        check_reset("rst");
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        check("cycle1_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        check("cycle2_req_valid", 32'(imem_req_valid), 32'd1);
        check("cycle2_req_addr", imem_req_addr, 32'h0);

        // Sequential fetch with 1-cycle memory: 0x0, 0x4, 0x8 four cycles apart.
        run_until_hs("seq_progress", 3, 40);
        check("seq_pc0", hs_pc[0], 32'h0);
        check("seq_pc1", hs_pc[1], 32'h4);
        check("seq_pc2", hs_pc[2], 32'h8);
        check("seq_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd4);
        check("seq_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd4);

        // Redirect while a slow response is pending: response dropped, refetch at 0x100.
        mem_lat = 3;
        wait_acc("wait_acc", 20);
        check("wait_acc_addr", last_acc_addr, 32'hC);
        base   = n_hs;
        jmp_en = 1'b1;
        jmp_to = 32'h100;
        step();
        wait_req("wait_redir", 32'h100, 20);
        check("wait_redir_no_inst", 32'(n_hs), 32'(base));
        mem_lat = 1;

        // Redirect in HOLD with a same-cycle decode handshake.
        inst_ready = 1'b0;
        wait_inst("hold_inst", 20);
        base       = n_hs;
        inst_ready = 1'b1;
        jmp_en     = 1'b1;
        jmp_to     = 32'h200;
        step();
        check("hold_consumed", 32'(n_hs), 32'(base + 1));
        check("hold_consumed_pc", hs_pc[base], 32'h100);
        check("hold_redir_valid", 32'(imem_req_valid), 32'd1);
        check("hold_redir_addr", imem_req_addr, 32'h200);
        check("hold_redir_inst_valid", 32'(inst_valid), 32'd0);

        // Misaligned target, then request stalled for five cycles.
        inst_ready = 1'b0;
        wait_inst("mis_inst", 20);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        jmp_en         = 1'b1;
        jmp_to         = 32'h103;
        step();
        check("mis_pulse", 32'(misalign_err), 32'd1);
        check("mis_addr", imem_req_addr, 32'h100);
        repeat (5) step();
        check("stall_pulse_gone", 32'(misalign_err), 32'd0);
        check("stall_valid", 32'(imem_req_valid), 32'd1);
        check("stall_addr", imem_req_addr, 32'h100);
        imem_req_ready = 1'b1;

        // Wrap from the top of the address space.
        wait_inst("wrap_inst", 20);
        jmp_en = 1'b1;
        jmp_to = 32'hFFFF_FFFC;
        step();
        base = n_hs;
        run_until_hs("wrap_progress", base + 2, 40);
        check("wrap_pc_top", hs_pc[base], 32'hFFFF_FFFC);
        check("wrap_pc_zero", hs_pc[base + 1], 32'h0);

        // Reset asserted while a response is outstanding.
        mem_lat = 3;
        wait_acc("rstw_acc", 20);
        rst = 1'b1;
        step();
        check_reset("rst_wait");
        step();
        rst     = 1'b0;
        mem_lat = 1;
        check("rstw_cycle1_valid", 32'(imem_req_valid), 32'd0);
        step();
        check("rstw_cycle2_valid", 32'(imem_req_valid), 32'd1);
        check("rstw_cycle2_addr", imem_req_addr, 32'h0);

        // Randomized traffic checked against the fetch-stream model.
        rand_lat = 1'b1;
        base     = n_hs;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 15) == 0) begin
                jmp_en = 1'b1;
                jmp_to = $urandom;
            end
            step();
        end
        check("rand_progress", 32'(n_hs - base >= 50), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
